taint_stop_monitor: RTL and testbench
=====================================

# taint_stop_monitor

Synthesizable run-control monitor that sits directly downstream of the taint-instrumented `scarv_tiny_soc` in the unclocked CellIFT flow. It consumes the SoC's data-memory bus, the bus taint shadows and the fetch-address taint. It detects stop requests, trap signals, PC taint, tainted-address accesses and bus taint transit. It sequences a fixed drain window before asserting `done_o`, and records first-occurrence step stamps so the bench reads results instead of re-deriving them.

## Interface
Parameters:
- `AddrWidth`, 15, data-memory word-address width.
- `StopAddr`, 0, word address whose write is a stop request.
- `TrapAddr`, 8, word address whose write is a trap signal.
- `DrainCycles`, 50, cycles kept running after a stop trigger.

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1: clock.
- `rst_ni` in 1: async active-low reset.
- `en_i` in 1: core out of reset; starts monitoring.
- `simlen_i` in 32: run-length limit in steps; 0 = unlimited.
- `stop_on_trap_i` in 1: trap signal triggers drain when 1.
- `dmem_req_i`, `dmem_we_i` in 1: data bus request and write enable.
- `dmem_addr_i` in AddrWidth: data bus word address.
- `dmem_addr_t0_i` in AddrWidth: address taint.
- `dmem_wdata_t0_i` in 32: write-data taint.
- `dmem_rdata_t0_i` in 32: read-data taint.
- `pc_t0_i` in 32: fetch next-address taint.
- `state_o` out 2: IDLE=0, RUN=1, DRAIN=2, DONE=3.
- `done_o` out 1: state is DONE.
- `cause_o` out 3: 0 none, 1 pc_taint, 2 stop, 3 trap, 4 simlen.
- `step_o` out 32: current step index.
- `stop_seen_o`, `trap_seen_o`, `pc_taint_o`, `addr_taint_o`, `bus_taint_o` out 1: sticky event flags.
- `dest_taint_o` out 1: write-data taint captured at the stop request.
- `pc_taint_step_o`, `bus_taint_step_o` out 32: step of first occurrence.

## Operation
- All outputs reset to 0 and state resets to IDLE.
- IDLE→RUN on the first edge with `en_i`=1. No events are sampled in IDLE.
- Events are evaluated in RUN and DRAIN only:
  - stop_hit = req & we & addr==StopAddr
  - trap_hit = req & we & addr==TrapAddr
  - pcT = |pc_t0_i
  - addrT = |dmem_addr_t0_i (not gated by req)
  - busT = |dmem_rdata_t0_i
- Sticky flags set on their event. `step_o` stamps are captured only on the first occurrence.
- Stop request: the first stop_hit sets `stop_seen_o` and loads `dest_taint_o` = |`dmem_wdata_t0_i`. Later stop_hits change nothing.
- Trigger in RUN is pcT, stop_hit, or (trap_hit & `stop_on_trap_i`). A trigger moves RUN→DRAIN and loads the drain counter with DrainCycles.
  - `cause_o` is latched once, by priority pc_taint > stop > trap.
  - A trap_hit with `stop_on_trap_i`=0 only sets `trap_seen_o`.
- DRAIN: triggers are ignored for state and cause; flags and stamps keep updating. The counter decrements each edge. An edge with counter==0 moves to DONE.
- Simlen: on an edge in RUN or DRAIN with `simlen_i`≠0 and `step_o`==`simlen_i`−1, go to DONE.
  - `cause_o`=4 only if still 0.
  - This has priority over entering DRAIN on the same edge, but events of that cycle are still recorded.
- DONE is terminal until reset: flags, stamps and `step_o` freeze.
- `step_o` increments on every RUN/DRAIN edge and saturates at 0xFFFFFFFF. Stamps use the pre-increment value.
- Reset asserted mid-run returns everything to reset values immediately (async).

## Timing
- Inputs are sampled at `clk_i` rising edge. All outputs are registered; no combinational input→output paths.
- Trigger sampled at edge k → `state_o`=DRAIN after k → `done_o`=1 after edge k+DrainCycles+1.
- With DrainCycles=0, DONE follows at edge k+1.
- Flag and stamp latency: 1 cycle after the sampling edge.
- The drain counter is $clog2(DrainCycles+1) bits wide, minimum 1.

## Test plan
- Stop path: en at step 0; write to addr 0 at step 20 with wdata_t0=0x1 → cause=2, `dest_taint_o`=1, DRAIN at step 21, `done_o` after 51 further edges.
- Trap gating: write to addr 8 at step 5 with `stop_on_trap_i`=0 → `trap_seen_o`=1, state stays RUN. Repeat with `stop_on_trap_i`=1 → cause=3.
- Simultaneous triggers: pc_t0=0x4 and stop_hit on the same edge at step 7 → cause=1, `pc_taint_step_o`=7, `stop_seen_o`=1.
- Simlen: `simlen_i`=12, no events → DONE after step 11, cause=4, `step_o`=12. Simlen reached during DRAIN → DONE early, cause unchanged.
- Bus and address taint: rdata_t0=0x80 at step 3, again at step 9; addr_t0≠0 with req=0 → `bus_taint_step_o`=3, `addr_taint_o`=1, no state change.
- Reset mid-DRAIN: drop `rst_ni` asynchronously → all outputs 0 and IDLE without waiting for a clock edge. Release with `en_i`=1 → RUN, stamps cleared.

Source files
------------

// File: rtl/taint_stop_monitor.sv
// Run-control monitor for the taint-instrumented SoC: watches the data bus and
// taint shadows, sequences RUN -> DRAIN -> DONE and records first-event step stamps.
module taint_stop_monitor #(
  parameter int unsigned AddrWidth   = 15,
  parameter int unsigned StopAddr    = 0,
  parameter int unsigned TrapAddr    = 8,
  parameter int unsigned DrainCycles = 50
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [31:0]          simlen_i,
  input  logic                 stop_on_trap_i,
  input  logic                 dmem_req_i,
  input  logic                 dmem_we_i,
  input  logic [AddrWidth-1:0] dmem_addr_i,
  input  logic [AddrWidth-1:0] dmem_addr_t0_i,
  input  logic [31:0]          dmem_wdata_t0_i,
  input  logic [31:0]          dmem_rdata_t0_i,
  input  logic [31:0]          pc_t0_i,
  output logic [1:0]           state_o,
  output logic                 done_o,
  output logic [2:0]           cause_o,
  output logic [31:0]          step_o,
  output logic                 stop_seen_o,
  output logic                 trap_seen_o,
  output logic                 pc_taint_o,
  output logic                 addr_taint_o,
  output logic                 bus_taint_o,
  output logic                 dest_taint_o,
  output logic [31:0]          pc_taint_step_o,
  output logic [31:0]          bus_taint_step_o
);

  localparam int unsigned CntLog = $clog2(DrainCycles + 1);
  localparam int unsigned CntW   = (CntLog < 1) ? 1 : CntLog;

  localparam logic [2:0] CauseNone   = 3'd0;
  localparam logic [2:0] CausePc     = 3'd1;
  localparam logic [2:0] CauseStop   = 3'd2;
  localparam logic [2:0] CauseTrap   = 3'd3;
  localparam logic [2:0] CauseSimlen = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_cause;
  logic [31:0]     r_step;
  logic            r_stop_seen;
  logic            r_trap_seen;
  logic            r_pc_taint;
  logic            r_addr_taint;
  logic            r_bus_taint;
  logic            r_dest_taint;
  logic [31:0]     r_pc_step;
  logic [31:0]     r_bus_step;

  logic        w_stop_hit;
  logic        w_trap_hit;
  logic        w_pc_t;
  logic        w_addr_t;
  logic        w_bus_t;
  logic        w_trigger;
  logic        w_simlen_hit;
  logic [2:0]  w_trig_cause;
  logic [31:0] w_step_next;

  // Event decode; address taint is deliberately not qualified by the request.
  assign w_stop_hit   = dmem_req_i & dmem_we_i & (dmem_addr_i == AddrWidth'(StopAddr));
  assign w_trap_hit   = dmem_req_i & dmem_we_i & (dmem_addr_i == AddrWidth'(TrapAddr));
  assign w_pc_t       = |pc_t0_i;
  assign w_addr_t     = |dmem_addr_t0_i;
  assign w_bus_t      = |dmem_rdata_t0_i;
  assign w_trigger    = w_pc_t | w_stop_hit | (w_trap_hit & stop_on_trap_i);
  assign w_trig_cause = w_pc_t ? CausePc : (w_stop_hit ? CauseStop : CauseTrap);
  assign w_simlen_hit = (simlen_i != 32'd0) && (r_step == simlen_i - 32'd1);
  assign w_step_next  = (&r_step) ? r_step : r_step + 32'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_cause      <= CauseNone;
      r_step       <= '0;
      r_stop_seen  <= 1'b0;
      r_trap_seen  <= 1'b0;
      r_pc_taint   <= 1'b0;
      r_addr_taint <= 1'b0;
      r_bus_taint  <= 1'b0;
      r_dest_taint <= 1'b0;
      r_pc_step    <= '0;
      r_bus_step   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en_i) r_state <= ST_RUN;
        end
        ST_RUN, ST_DRAIN: begin
          r_step <= w_step_next;
          if (w_pc_t && !r_pc_taint) begin
            r_pc_taint <= 1'b1;
            r_pc_step  <= r_step;
          end
          if (w_bus_t && !r_bus_taint) begin
            r_bus_taint <= 1'b1;
            r_bus_step  <= r_step;
          end
          if (w_addr_t)   r_addr_taint <= 1'b1;
          if (w_trap_hit) r_trap_seen  <= 1'b1;
          if (w_stop_hit && !r_stop_seen) begin
            r_stop_seen  <= 1'b1;
            r_dest_taint <= |dmem_wdata_t0_i;
          end
          // Run-length limit wins over a same-edge trigger and cuts a drain short.
          if (w_simlen_hit) begin
            r_state <= ST_DONE;
            if (r_cause == CauseNone) r_cause <= CauseSimlen;
          end else if (r_state == ST_RUN) begin
            if (w_trigger) begin
              r_state <= ST_DRAIN;
              r_cnt   <= CntW'(DrainCycles);
              r_cause <= w_trig_cause;
            end
          end else if (r_cnt == '0) begin
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o          = r_state;
  assign done_o           = (r_state == ST_DONE);
  assign cause_o          = r_cause;
  assign step_o           = r_step;
  assign stop_seen_o      = r_stop_seen;
  assign trap_seen_o      = r_trap_seen;
  assign pc_taint_o       = r_pc_taint;
  assign addr_taint_o     = r_addr_taint;
  assign bus_taint_o      = r_bus_taint;
  assign dest_taint_o     = r_dest_taint;
  assign pc_taint_step_o  = r_pc_step;
  assign bus_taint_step_o = r_bus_step;

endmodule

// File: tb/tb_taint_stop_monitor.sv
// Self-checking bench for taint_stop_monitor: scenario table with scoreboard queue
// plus hand-written sequences for reset, exact drain timing and async reset.
module tb_taint_stop_monitor;

  localparam int unsigned AW = 15;

  logic          clk_i;
  logic          rst_ni;
  logic          en_i;
  logic [31:0]   simlen_i;
  logic          stop_on_trap_i;
  logic          dmem_req_i;
  logic          dmem_we_i;
  logic [AW-1:0] dmem_addr_i;
  logic [AW-1:0] dmem_addr_t0_i;
  logic [31:0]   dmem_wdata_t0_i;
  logic [31:0]   dmem_rdata_t0_i;
  logic [31:0]   pc_t0_i;
  logic [1:0]    state_o;
  logic          done_o;
  logic [2:0]    cause_o;
  logic [31:0]   step_o;
  logic          stop_seen_o;
  logic          trap_seen_o;
  logic          pc_taint_o;
  logic          addr_taint_o;
  logic          bus_taint_o;
  logic          dest_taint_o;
  logic [31:0]   pc_taint_step_o;
  logic [31:0]   bus_taint_step_o;

  int n_tests;
  int n_fail;

  taint_stop_monitor #(
    .AddrWidth(AW), .StopAddr(0), .TrapAddr(8), .DrainCycles(50)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .simlen_i(simlen_i),
    .stop_on_trap_i(stop_on_trap_i), .dmem_req_i(dmem_req_i), .dmem_we_i(dmem_we_i),
    .dmem_addr_i(dmem_addr_i), .dmem_addr_t0_i(dmem_addr_t0_i),
    .dmem_wdata_t0_i(dmem_wdata_t0_i), .dmem_rdata_t0_i(dmem_rdata_t0_i),
    .pc_t0_i(pc_t0_i), .state_o(state_o), .done_o(done_o), .cause_o(cause_o),
    .step_o(step_o), .stop_seen_o(stop_seen_o), .trap_seen_o(trap_seen_o),
    .pc_taint_o(pc_taint_o), .addr_taint_o(addr_taint_o), .bus_taint_o(bus_taint_o),
    .dest_taint_o(dest_taint_o), .pc_taint_step_o(pc_taint_step_o),
    .bus_taint_step_o(bus_taint_step_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // kind: 0 none, 1 pc, 2 stop, 3 trap, 4 pc+stop, 5 bus (twice), 6 addr taint, 7 stop twice
  typedef struct {
    logic [31:0] simlen;
    logic        sot;
    int          ev;
    int          kind;
    logic [31:0] wd;
    int          run;
    logic [1:0]  e_state;
    logic [2:0]  e_cause;
    logic [31:0] e_step;
    logic        e_stop;
    logic        e_trap;
    logic        e_pc;
    logic        e_addr;
    logic        e_bus;
    logic        e_dest;
    logic [31:0] e_pcs;
    logic [31:0] e_buss;
  } vec_t;

  vec_t vecs[11];
  vec_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Background bus traffic that never writes the stop or trap address.
  task automatic idle_bus();
    dmem_addr_i     = AW'($urandom_range(0, 15));
    dmem_req_i      = 1'($urandom);
    dmem_we_i       = (dmem_addr_i == AW'(0) || dmem_addr_i == AW'(8)) ? 1'b0 : 1'($urandom);
    dmem_addr_t0_i  = '0;
    dmem_wdata_t0_i = '0;
    dmem_rdata_t0_i = '0;
    pc_t0_i         = '0;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] wd);
    dmem_req_i      = 1'b1;
    dmem_we_i       = 1'b1;
    dmem_addr_i     = a;
    dmem_wdata_t0_i = wd;
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    en_i           = 1'b0;
    simlen_i       = '0;
    stop_on_trap_i = 1'b0;
    idle_bus();
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'd0);
    chk({tag, ".done"}, 32'(done_o), 32'd0);
    chk({tag, ".cause"}, 32'(cause_o), 32'd0);
    chk({tag, ".step"}, step_o, 32'd0);
    chk({tag, ".stop"}, 32'(stop_seen_o), 32'd0);
    chk({tag, ".trap"}, 32'(trap_seen_o), 32'd0);
    chk({tag, ".pc"}, 32'(pc_taint_o), 32'd0);
    chk({tag, ".addr"}, 32'(addr_taint_o), 32'd0);
    chk({tag, ".bus"}, 32'(bus_taint_o), 32'd0);
    chk({tag, ".dest"}, 32'(dest_taint_o), 32'd0);
    chk({tag, ".pcs"}, pc_taint_step_o, 32'd0);
    chk({tag, ".buss"}, bus_taint_step_o, 32'd0);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    vec_t e;
    string t;
    v = vecs[i];
    sb_q.push_back(v);
    do_reset();
    simlen_i       = v.simlen;
    stop_on_trap_i = v.sot;
    en_i           = 1'b1;
    tick();
    for (int c = 0; c < v.run; c++) begin
      idle_bus();
      case (v.kind)
        1: if (c == v.ev) pc_t0_i = 32'h4;
        2: if (c == v.ev) bus_write(AW'(0), v.wd);
        3: if (c == v.ev) bus_write(AW'(8), v.wd);
        4: if (c == v.ev) begin bus_write(AW'(0), v.wd); pc_t0_i = 32'h4; end
        5: if (c == v.ev || c == v.ev + 6) dmem_rdata_t0_i = 32'h80;
        6: if (c == v.ev) begin dmem_req_i = 1'b0; dmem_we_i = 1'b0; dmem_addr_t0_i = AW'(16); end
        7: begin
          if (c == v.ev) bus_write(AW'(0), v.wd);
          if (c == v.ev + 3) bus_write(AW'(0), 32'hFF);
        end
        default: ;
      endcase
      tick();
    end
    idle_bus();
    e = sb_q.pop_front();
    t = $sformatf("v%0d", i);
    chk({t, ".state"}, 32'(state_o), 32'(e.e_state));
    chk({t, ".done"}, 32'(done_o), 32'(e.e_state == 2'd3));
    chk({t, ".cause"}, 32'(cause_o), 32'(e.e_cause));
    chk({t, ".step"}, step_o, e.e_step);
    chk({t, ".stop"}, 32'(stop_seen_o), 32'(e.e_stop));
    chk({t, ".trap"}, 32'(trap_seen_o), 32'(e.e_trap));
    chk({t, ".pc"}, 32'(pc_taint_o), 32'(e.e_pc));
    chk({t, ".addr"}, 32'(addr_taint_o), 32'(e.e_addr));
    chk({t, ".bus"}, 32'(bus_taint_o), 32'(e.e_bus));
    chk({t, ".dest"}, 32'(dest_taint_o), 32'(e.e_dest));
    chk({t, ".pcs"}, pc_taint_step_o, e.e_pcs);
    chk({t, ".buss"}, bus_taint_step_o, e.e_buss);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    //          simlen sot ev kind wd   run st cause step stop trap pc addr bus dest pcs buss
    vecs[0]  = '{32'd0,  1'b0, 20, 2, 32'h1, 21, 2'd2, 3'd2, 32'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[1]  = '{32'd0,  1'b0, 20, 2, 32'h1, 80, 2'd3, 3'd2, 32'd72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0};
    vecs[2]  = '{32'd0,  1'b0, 5,  3, 32'h0, 10, 2'd1, 3'd0, 32'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[3]  = '{32'd0,  1'b1, 5,  3, 32'h0, 10, 2'd2, 3'd3, 32'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[4]  = '{32'd0,  1'b0, 7,  4, 32'h0, 10, 2'd2, 3'd1, 32'd10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd7, 32'd0};
    vecs[5]  = '{32'd12, 1'b0, 0,  0, 32'h0, 20, 2'd3, 3'd4, 32'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[6]  = '{32'd0,  1'b0, 3,  5, 32'h0, 15, 2'd1, 3'd0, 32'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd3};
    vecs[7]  = '{32'd0,  1'b0, 4,  6, 32'h0, 10, 2'd1, 3'd0, 32'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[8]  = '{32'd30, 1'b0, 10, 2, 32'h0, 40, 2'd3, 3'd2, 32'd30, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[9]  = '{32'd6,  1'b0, 5,  1, 32'h0, 10, 2'd3, 3'd4, 32'd6,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0};
    vecs[10] = '{32'd0,  1'b0, 2,  7, 32'h0, 10, 2'd2, 3'd2, 32'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};

    // Reset values, before any clock edge.
    rst_ni         = 1'b0;
    en_i           = 1'b0;
    simlen_i       = '0;
    stop_on_trap_i = 1'b0;
    idle_bus();
    #3;
    check_all_zero("rst");
    #3;
    rst_ni = 1'b1;

    // IDLE ignores events until enabled.
    pc_t0_i = 32'h4;
    repeat (3) tick();
    chk("idle.state", 32'(state_o), 32'd0);
    chk("idle.pc", 32'(pc_taint_o), 32'd0);
    chk("idle.step", step_o, 32'd0);
    pc_t0_i = '0;
    en_i    = 1'b1;
    tick();
    chk("en.state", 32'(state_o), 32'd1);
    chk("en.step", step_o, 32'd0);

    // Exact drain length: trigger at edge k, DONE only after edge k+51.
    pc_t0_i = 32'h4;
    tick();
    pc_t0_i = '0;
    chk("drain.state", 32'(state_o), 32'd2);
    chk("drain.cause", 32'(cause_o), 32'd1);
    chk("drain.pcs", pc_taint_step_o, 32'd0);
    repeat (50) tick();
    chk("drain.last_done", 32'(done_o), 32'd0);
    chk("drain.last_state", 32'(state_o), 32'd2);
    tick();
    chk("drain.done", 32'(done_o), 32'd1);
    chk("drain.step", step_o, 32'd52);
    repeat (3) tick();
    chk("done.frozen_step", step_o, 32'd52);

    for (int i = 0; i < 11; i++) run_vec(i);

    // Asynchronous reset in the middle of a drain.
    do_reset();
    en_i = 1'b1;
    tick();
    bus_write(AW'(0), 32'h1);
    tick();
    idle_bus();
    repeat (5) tick();
    chk("mid.state", 32'(state_o), 32'd2);
    #2;
    rst_ni = 1'b0;
    #1;
    check_all_zero("async");
    #1;
    rst_ni = 1'b1;
    tick();
    chk("rel.state", 32'(state_o), 32'd1);
    chk("rel.step", step_o, 32'd0);
    chk("rel.stop", 32'(stop_seen_o), 32'd0);
    chk("rel.pcs", pc_taint_step_o, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
